// File: rtl/kvi_pkg.sv
// Shared types for the key-value Wishbone initiator: FSM states, command record, bus widths.
package kvi_pkg;

  localparam int KVI_DATA_W = 8;
  localparam int KVI_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } kvi_state_e;

  typedef struct packed {
    logic                  we;
    logic [KVI_ADDR_W-1:0] key;
    logic [KVI_DATA_W-1:0] val;
  } kvi_cmd_t;

endpackage

// File: rtl/kvi_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through output; DEPTH must be a power of 2.
module kvi_cmd_fifo
  import kvi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  logic     pop_i,
  input  kvi_cmd_t din_i,
  output kvi_cmd_t dout_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  kvi_cmd_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/keyvalue_wb_initiator.sv
// Wishbone classic initiator for the 8-bit key-value responder: one bus cycle per queued command.
// Optional ACK timeout abort is enabled by defining KVI_TIMEOUT_EN.
module keyvalue_wb_initiator
  import kvi_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_key,
  input  logic [7:0]  cmd_val,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        CYC_o,
  output logic        STB_o,
  output logic        WE_o,
  output logic        SEL_o,
  output logic [7:0]  ADR_o,
  output logic [7:0]  DAT_o,
  input  logic [7:0]  DAT_i,
  input  logic        ACK_i,
  output logic [15:0] txn_count
);

  kvi_state_e state_q, state_d;
  kvi_cmd_t   cmd_in, fifo_head;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic       init_q, init_d;
  logic       cyc_q, cyc_d, we_q, we_d;
  logic [KVI_ADDR_W-1:0] adr_q, adr_d;
  logic [KVI_DATA_W-1:0] dat_q, dat_d, rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [15:0] txn_q, txn_d;
  logic       timeout_hit, bus_done;

  assign cmd_in    = {cmd_we, cmd_key, cmd_val};
  assign cmd_ready = init_q && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign bus_done  = (state_q == BUS) && (ACK_i || timeout_hit);

  kvi_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (cmd_in),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      init_q      <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      txn_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      txn_q       <= txn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = BUS;
      BUS:     if (bus_done)    state_d = RESP;
      RESP:    if (rsp_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    init_d      = 1'b1;
    fifo_pop    = 1'b0;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    txn_d       = txn_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        cyc_d    = 1'b1;
        we_d     = fifo_head.we;
        adr_d    = fifo_head.key;
        dat_d    = fifo_head.val;
      end
      // Timeout without ACK leaves data at zero; a PUT always returns zero.
      BUS: if (bus_done) begin
        cyc_d       = 1'b0;
        we_d        = 1'b0;
        adr_d       = '0;
        dat_d       = '0;
        rsp_valid_d = 1'b1;
        rsp_data_d  = (ACK_i && !we_q) ? DAT_i : '0;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        txn_d       = txn_q + 16'd1;
      end
      default: ;
    endcase
  end

`ifdef KVI_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_q, wait_d;
  logic        rsp_err_q, rsp_err_d;

  // ACK is checked before the timeout, so an ACK on the last cycle wins.
  assign timeout_hit = (wait_q == WAIT_LAST);
  assign rsp_err     = rsp_err_q;

  always_comb begin
    wait_d    = wait_q;
    rsp_err_d = rsp_err_q;
    if (state_q != BUS) wait_d = '0;
    else if (!bus_done) wait_d = wait_q + 16'd1;
    if (bus_done) rsp_err_d = !ACK_i;
    else if (state_q == RESP && rsp_ready) rsp_err_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wait_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
  assign rsp_err            = 1'b0;
`endif

  assign CYC_o     = cyc_q;
  assign STB_o     = cyc_q;
  assign SEL_o     = cyc_q;
  assign WE_o      = we_q;
  assign ADR_o     = adr_q;
  assign DAT_o     = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_keyvalue_wb_initiator.sv
// Randomized and directed bench for keyvalue_wb_initiator against a queue-based reference model.
module tb_keyvalue_wb_initiator;

  localparam int DEPTH = 4;
  localparam int TO    = 8;
  localparam logic [7:0] RD_XOR = 8'hB7;

  logic        sys_clk, sys_rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_key, cmd_val;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  rsp_data;
  logic        CYC_o, STB_o, WE_o, SEL_o, ACK_i;
  logic [7:0]  ADR_o, DAT_o, DAT_i;
  logic [15:0] txn_count;

  int n_cmp = 0;
  int n_bad = 0;

  keyvalue_wb_initiator #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_key(cmd_key), .cmd_val(cmd_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .CYC_o(CYC_o), .STB_o(STB_o), .WE_o(WE_o), .SEL_o(SEL_o),
    .ADR_o(ADR_o), .DAT_o(DAT_o), .DAT_i(DAT_i), .ACK_i(ACK_i),
    .txn_count(txn_count)
  );

  // Responder returns a key-derived byte so read data also proves the address.
  assign DAT_i = ADR_o ^ RD_XOR;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: command queue, one outstanding bus cycle, one pending response.
  typedef struct { bit we; bit [7:0] key; bit [7:0] val; } cmd_s;
  cmd_s       mq[$];
  cmd_s       cur;
  bit         live = 0, m_init = 0, m_on_bus = 0, m_in_rsp = 0, m_err = 0;
  int         m_age = 0;
  bit [7:0]   m_rdata = 0;
  bit [15:0]  m_done = 0;
  bit [15:0]  m_base = 0;

  always @(posedge sys_clk) begin
    bit acc;
    acc  = cmd_valid && m_init && (mq.size() < DEPTH);
    live = 1;
    if (!sys_rst_n) begin
      mq.delete();
      m_init = 0; m_on_bus = 0; m_in_rsp = 0; m_done = 0; m_err = 0;
    end else begin
      if (m_in_rsp) begin
        if (rsp_ready) begin m_in_rsp = 0; m_done++; end
      end else if (m_on_bus) begin
        m_age++;
        if (ACK_i) begin
          m_on_bus = 0; m_in_rsp = 1; m_err = 0;
          m_rdata  = cur.we ? 8'h00 : (cur.key ^ RD_XOR);
        end
`ifdef KVI_TIMEOUT_EN
        else if (m_age == TO) begin
          m_on_bus = 0; m_in_rsp = 1; m_err = 1; m_rdata = 8'h00;
        end
`endif
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        m_on_bus = 1;
        m_age = 0;
      end
      if (acc) mq.push_back('{cmd_we, cmd_key, cmd_val});
      m_init = 1;
    end
  end

  always @(negedge sys_clk) begin
    bit [15:0] exp_txn;
    if (live) begin
      exp_txn = m_base + m_done;
      check("cmd_ready", cmd_ready, m_init && (mq.size() < DEPTH));
      check("CYC_o", CYC_o, m_on_bus);
      check("STB_o", STB_o, m_on_bus);
      check("SEL_o", SEL_o, m_on_bus);
      check("WE_o",  WE_o,  m_on_bus && cur.we);
      check("ADR_o", ADR_o, m_on_bus ? cur.key : 8'h00);
      check("DAT_o", DAT_o, m_on_bus ? cur.val : 8'h00);
      check("rsp_valid", rsp_valid, m_in_rsp);
      if (m_in_rsp) begin
        check("rsp_data", rsp_data, m_rdata);
        check("rsp_err",  rsp_err,  m_err);
      end
      check("txn_count", txn_count, exp_txn);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_cmd(input bit we, input bit [7:0] key, input bit [7:0] val);
    int n = 0;
    cmd_valid = 1; cmd_we = we; cmd_key = key; cmd_val = val;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_txn(input bit [15:0] target);
    int n = 0;
    while (txn_count !== target && n < 80) begin tick(); n++; end
    check("wait_txn", txn_count, target);
  endtask

  initial begin
    int hi;
    sys_rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_key = 0; cmd_val = 0;
    ACK_i = 0; rsp_ready = 0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cyc", CYC_o, 0);
    check("rst_txn", txn_count, 0);
    sys_rst_n = 1;
    tick();
    check("post_rst_ready", cmd_ready, 1);

    // PUT 0x12/0xA5, ACK after three wait cycles
    push_cmd(1, 8'h12, 8'hA5);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_cyc", CYC_o, 1);
      check("t1_adr", ADR_o, 8'h12);
      check("t1_dat", DAT_o, 8'hA5);
      check("t1_we",  WE_o, 1);
      if (i == 3) ACK_i = 1;
      tick();
    end
    ACK_i = 0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_data", rsp_data, 8'h00);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_cyc_drop", CYC_o, 0);
    rsp_ready = 1; tick(); rsp_ready = 0;
    check("t1_txn", txn_count, 16'd1);

    // GET 0x12, response held while consumer stalls
    push_cmd(0, 8'h12, 8'h00);
    tick();
    check("t2_we", WE_o, 0);
    check("t2_cyc", CYC_o, 1);
    ACK_i = 1; tick(); ACK_i = 0;
    for (int i = 0; i < 5; i++) begin
      check("t2_rsp_valid", rsp_valid, 1);
      check("t2_rsp_data", rsp_data, 8'hA5);
      tick();
    end
    rsp_ready = 1; tick(); rsp_ready = 0;
    check("t2_txn", txn_count, 16'd2);

    // Five back-to-back GETs with ACK withheld fill the FIFO
    for (int i = 0; i < 5; i++) push_cmd(0, 8'h50 + 8'(i), 8'h00);
    check("t3_full", cmd_ready, 0);
    check("t3_adr", ADR_o, 8'h50);
    ACK_i = 1; rsp_ready = 1;
    wait_txn(16'd7);
    ACK_i = 0; rsp_ready = 0;

    // Reset mid bus cycle
    push_cmd(0, 8'h40, 8'h00);
    push_cmd(1, 8'h41, 8'h77);
    tick();
    check("t4_in_bus", CYC_o, 1);
    sys_rst_n = 0; tick();
    check("t4_cyc", CYC_o, 0);
    check("t4_stb", STB_o, 0);
    check("t4_rsp", rsp_valid, 0);
    check("t4_txn", txn_count, 0);
    sys_rst_n = 1; tick(); tick();
    check("t4_fifo_empty", CYC_o, 0);
    check("t4_ready", cmd_ready, 1);

    // Counter wrap from a preloaded 0xFFFF
    force dut.txn_q = 16'hFFFF;
    m_base = 16'hFFFF - m_done;
    tick();
    release dut.txn_q;
    tick();
    check("t6_pre", txn_count, 16'hFFFF);
    ACK_i = 1; rsp_ready = 1;
    push_cmd(1, 8'h22, 8'h33);
    wait_txn(16'h0000);
    ACK_i = 0; rsp_ready = 0;

`ifdef KVI_TIMEOUT_EN
    // No ACK: bus held TO cycles, then an error response
    push_cmd(0, 8'h33, 8'h00);
    hi = 0;
    for (int i = 0; i < 30 && !rsp_valid; i++) begin
      tick();
      if (CYC_o) hi++;
    end
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_bus_cycles", hi, TO);
    check("t5_err", rsp_err, 1);
    check("t5_data", rsp_data, 8'h00);
    rsp_ready = 1; tick(); rsp_ready = 0;
    ACK_i = 1;
    push_cmd(0, 8'h34, 8'h00);
    hi = 0;
    while (!rsp_valid && hi < 20) begin tick(); hi++; end
    ACK_i = 0;
    check("t5_next_err", rsp_err, 0);
    check("t5_next_data", rsp_data, 8'h34 ^ RD_XOR);
    rsp_ready = 1; tick(); rsp_ready = 0;
`endif

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_we    = ($urandom_range(0, 1) == 1);
      cmd_key   = 8'($urandom);
      cmd_val   = 8'($urandom);
      ACK_i     = ($urandom_range(0, 9) < 4);
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    cmd_valid = 0; ACK_i = 1; rsp_ready = 1;
    repeat (30) tick();
    check("drain_idle", CYC_o, 0);
    check("drain_rsp", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
